// File: rtl/mitchel_div_pipe.sv
// mitchel_div_pipe
// ----------------
// Three-stage pipelined signed divider using Mitchell's logarithmic
// approximation. Each operand is split into a leading-one position k and
// an 8-bit fraction f; the quotient is rebuilt from e = kx - ky and the
// fraction difference, which gives a Q10.8 result.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   x, y       signed 9-bit dividend / divisor
//   in_valid   operand pair valid
//   in_ready   operand pair accepted when high together with in_valid
//   q          signed Q10.8 quotient (18 bits)
//   dz         divide-by-zero flag, qualified by out_valid
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   done_cnt   count of completed output handshakes (wraps)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer. The whole pipe advances as one unit (en = !out_valid ||
// out_ready). While the output is stalled nothing moves, bubbles included,
// and in_ready stays low.

module mitchel_div_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  x,
  input  logic [8:0]  y,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [17:0] q,
  output logic        dz,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] done_cnt
);

  // Position of the most significant set bit. Returns 0 for a zero input.
  // Callers use the zero flags to cover that case.
  function automatic logic [3:0] lead_pos(input logic [8:0] a);
    lead_pos = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (a[i]) lead_pos = 4'(i);
    end
  endfunction

  // Bits below the leading one, left-aligned into 8 fraction bits.
  function automatic logic [7:0] frac_of(input logic [8:0] a, input logic [3:0] k);
    logic [8:0] rem;
    logic [8:0] sh;
    rem = a & ~(9'd1 << k);
    sh  = rem << (4'd8 - k);
    return sh[7:0];
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------------
  // Stage 1 input logic: magnitudes, leading-one positions, fractions
  // ---------------------------------------------------------------------
  logic [8:0] ax, ay;
  logic [3:0] kx_c, ky_c;
  logic [7:0] fx_c, fy_c;

  // |-256| = 256 still fits as a 9-bit unsigned value.
  assign ax   = x[8] ? 9'(~x + 9'd1) : x;
  assign ay   = y[8] ? 9'(~y + 9'd1) : y;
  assign kx_c = lead_pos(ax);
  assign ky_c = lead_pos(ay);
  assign fx_c = frac_of(ax, kx_c);
  assign fy_c = frac_of(ay, ky_c);

  logic       s1_v;
  logic       s1_sign, s1_xz, s1_yz;
  logic [3:0] s1_kx, s1_ky;
  logic [7:0] s1_fx, s1_fy;

  // ---------------------------------------------------------------------
  // Stage 2 input logic: exponent difference and mantissa select
  // ---------------------------------------------------------------------
  logic              fx_ge;
  logic [8:0]        diff9;
  logic [8:0]        m_c;
  logic signed [4:0] e_raw, e_c;

  assign fx_ge = s1_fx >= s1_fy;
  assign e_raw = $signed({1'b0, s1_kx}) - $signed({1'b0, s1_ky});
  // Modulo-512 difference. When fx < fy it already equals 512 + fx - fy,
  // so only the fx >= fy branch needs the implicit leading one added.
  assign diff9 = {1'b0, s1_fx} - {1'b0, s1_fy};
  assign m_c   = fx_ge ? (9'h100 + diff9) : diff9;
  assign e_c   = fx_ge ? e_raw : (e_raw - 5'sd1);

  logic              s2_v;
  logic              s2_sign, s2_xz, s2_yz;
  logic [8:0]        s2_m;
  logic signed [4:0] s2_e;

  // ---------------------------------------------------------------------
  // Stage 3 input logic: denormalise, apply sign, handle zero operands
  // ---------------------------------------------------------------------
  logic [16:0] mag;
  logic [4:0]  rsh;
  logic [17:0] q_c;
  logic        dz_c;

  always_comb begin
    mag = 17'd0;
    rsh = 5'd0;
    if (!s2_e[4]) begin
      mag = 17'(s2_m) << s2_e[3:0];
    end else begin
      // e ranges down to -9, so the right shift can push m to zero.
      rsh = 5'd0 - s2_e;
      mag = 17'(s2_m) >> rsh;
    end
  end

  always_comb begin
    q_c  = 18'd0;
    dz_c = 1'b0;
    if (s2_yz) begin
      // Divide by zero saturates toward the sign of x. 0/0 gives 0.
      dz_c = 1'b1;
      if (s2_xz)        q_c = 18'd0;
      else if (s2_sign) q_c = 18'h20001;
      else              q_c = 18'h1FFFF;
    end else if (s2_xz) begin
      q_c = 18'd0;
    end else if (s2_sign) begin
      q_c = 18'd0 - {1'b0, mag};
    end else begin
      q_c = {1'b0, mag};
    end
  end

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_sign   <= 1'b0;
      s1_xz     <= 1'b0;
      s1_yz     <= 1'b0;
      s1_kx     <= 4'd0;
      s1_ky     <= 4'd0;
      s1_fx     <= 8'd0;
      s1_fy     <= 8'd0;
      s2_v      <= 1'b0;
      s2_sign   <= 1'b0;
      s2_xz     <= 1'b0;
      s2_yz     <= 1'b0;
      s2_m      <= 9'd0;
      s2_e      <= 5'sd0;
      out_valid <= 1'b0;
      q         <= 18'd0;
      dz        <= 1'b0;
      done_cnt  <= 16'd0;
    end else begin
      if (en) begin
        s1_v      <= in_valid;
        s1_sign   <= x[8] ^ y[8];
        s1_xz     <= (x == 9'd0);
        s1_yz     <= (y == 9'd0);
        s1_kx     <= kx_c;
        s1_ky     <= ky_c;
        s1_fx     <= fx_c;
        s1_fy     <= fy_c;

        s2_v      <= s1_v;
        s2_sign   <= s1_sign;
        s2_xz     <= s1_xz;
        s2_yz     <= s1_yz;
        s2_m      <= m_c;
        s2_e      <= e_c;

        out_valid <= s2_v;
        // The visible result only changes when a real result arrives.
        if (s2_v) begin
          q  <= q_c;
          dz <= dz_c;
        end
      end
      if (out_valid && out_ready) begin
        done_cnt <= done_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mitchel_div_pipe.sv
// Testbench for mitchel_div_pipe: directed cases, stall, reset flush and
// randomized traffic, scored against an arithmetic model of the quotient.

module tb_mitchel_div_pipe;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  x, y;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] q;
  logic        dz;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] done_cnt;

  always #5 clk = ~clk;

  mitchel_div_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .dz        (dz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done_cnt  (done_cnt)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [18:0] exp_q[$];
  bit          rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {dz, q}.
  function automatic logic [18:0] model(input int xi, input int yi);
    int ax, ay, kx, ky, fx, fy, e, m, mag, val;
    if (yi == 0) begin
      if (xi > 0) return {1'b1, 18'h1FFFF};
      if (xi < 0) return {1'b1, 18'h20001};
      return {1'b1, 18'h00000};
    end
    if (xi == 0) return 19'h0;
    ax = (xi < 0) ? -xi : xi;
    ay = (yi < 0) ? -yi : yi;
    kx = 0;
    while ((1 << (kx + 1)) <= ax) kx++;
    ky = 0;
    while ((1 << (ky + 1)) <= ay) ky++;
    fx = (ax - (1 << kx)) * (1 << (8 - kx));
    fy = (ay - (1 << ky)) * (1 << (8 - ky));
    e  = kx - ky;
    if (fx >= fy) begin
      m = 256 + fx - fy;
    end else begin
      m = 512 + fx - fy;
      e = e - 1;
    end
    mag = (e >= 0) ? m * (1 << e) : m / (1 << (-e));
    val = ((xi < 0) != (yi < 0)) ? -mag : mag;
    return {1'b0, val[17:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int xi, input int yi);
    bit fire;
    int waited;
    waited   = 0;
    x        = 9'(xi);
    y        = 9'(yi);
    in_valid = 1'b1;
    forever begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      fire = in_ready;
      @(posedge clk);
      if (fire) begin
        exp_q.push_back(model(xi, yi));
        break;
      end
      waited++;
      if (waited > 200) begin
        check("send_timeout", 32'(waited), 32'd0);
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Samples 2 time units before the rising edge, after all drives settle.
  logic        prev_stall = 1'b0;
  logic [17:0] prev_q;
  logic        prev_dz;
  logic [18:0] mon_exp;

  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_q", 32'(q), 32'(prev_q));
        check("stall_dz", 32'(dz), 32'(prev_dz));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("q", 32'(q), 32'(mon_exp[17:0]));
          check("dz", 32'(dz), 32'(mon_exp[18]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_q     = q;
      prev_dz    = dz;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic any_ov;
    int   xr, yr;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = 9'd0;
    y         = 9'd0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);

    // Back-to-back: four operands on consecutive cycles.
    send(15, 5);
    send(100, 7);
    send(-27, 119);
    send(-256, 1);
    idle();
    for (int i = 0; i < 3; i++) begin
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_done_cnt", 32'(done_cnt), 32'(i + 1));
      tick();
    end
    check("b2b_done_final", 32'(done_cnt), 32'd4);
    check("b2b_valid_end", 32'(out_valid), 32'd0);
    drain();

    // Latency: result appears after exactly the third edge.
    send(15, 5);
    idle();
    check("lat_edge1", 32'(out_valid), 32'd0);
    tick();
    check("lat_edge2", 32'(out_valid), 32'd0);
    tick();
    check("lat_edge3", 32'(out_valid), 32'd1);
    check("lat_q", 32'(q), 32'd832);
    check("lat_dz", 32'(dz), 32'd0);
    drain();

    // Extremes and zero operands.
    send(-256, 1);
    send(1, -256);
    send(0, 18);
    send(5, 0);
    send(-5, 0);
    send(0, 0);
    send(255, 1);
    send(-256, -256);
    send(1, 255);
    idle();
    drain();

    // Stall: fill the pipe with out_ready low, hold for 5 cycles.
    out_ready = 1'b0;
    send(77, -3);
    send(-200, 9);
    send(13, 13);
    idle();
    check("stall_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    drain();

    // Randomized traffic with random gaps and backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       xr = 0;
        1:       xr = -256;
        default: xr = int'($urandom_range(0, 511)) - 256;
      endcase
      case ($urandom_range(0, 7))
        0:       yr = 0;
        1:       yr = ($urandom_range(0, 1) != 0) ? 1 : -256;
        default: yr = int'($urandom_range(0, 511)) - 256;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        idle();
        out_ready = ($urandom_range(0, 1) != 0);
        tick();
      end
      send(xr, yr);
    end
    idle();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with two operands in flight drops them.
    send(15, 5);
    send(100, 7);
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    any_ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      any_ov = any_ov | out_valid;
      tick();
    end
    check("rst_flush_no_out", 32'(any_ov), 32'd0);
    check("rst_flush_done_cnt", 32'(done_cnt), 32'd0);
    check("rst_flush_in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mitchel_div_pipe.md
MITCHEL_DIV_PIPE -- requirements
Module: mitchel_div_pipe

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 SHALL use one clock and a synchronous, active-low reset: `clk` input, 1 bit, rising-edge clock; `rst_n` input, 1 bit, synchronous active-low reset.
REQ-003 SHALL have the following data and handshake ports:
- `x` input, 9 bits, signed two's-complement dividend.
- `y` input, 9 bits, signed two's-complement divisor.
- `in_valid` input, 1 bit, operand pair valid.
- `in_ready` output, 1 bit, operand pair accepted when high together with `in_valid`.
- `q` output, 18 bits, signed quotient, Q10.8 (10 integer bits including sign, 8 fraction bits).
- `dz` output, 1 bit, divide-by-zero flag qualified by `out_valid`.
- `out_valid` output, 1 bit, result valid.
- `out_ready` input, 1 bit, consumer accepts the result.
- `done_cnt` output, 16 bits, count of completed output handshakes.

Function
REQ-004 SHALL compute the Mitchell logarithmic approximation of x/y:
- ax = |x| and ay = |y|, each 9 bits unsigned (0..256).
- k = position of the leading one (0..8).
- f = (a - 2^k) << (8-k), 8 bits.
REQ-005 SHALL form e = kx - ky (signed, -8..8) and select the mantissa:
- If fx >= fy: m = 256 + fx - fy.
- Otherwise: m = 512 + fx - fy, and e is decremented by 1.
- m is 9 bits unsigned Q1.8.
REQ-006 SHALL form the magnitude as m << e when e >= 0, or m >> (-e) when e < 0, truncating toward zero. The magnitude is at most 17 bits.
REQ-007 SHALL set the sign to x[8] XOR y[8], and `q` SHALL be the two's complement of the magnitude when the sign is 1.
REQ-008 SHALL force q = 0 and dz = 0 when x = 0 and y != 0.
REQ-009 SHALL handle y = 0 as follows:
- dz = 1.
- q = +131071 (18'h1FFFF) if x > 0.
- q = -131071 (18'h20001) if x < 0.
- q = 0 if x = 0.
REQ-010 SHALL be a 3-stage pipeline:
- S1 registers sign, ax/ay zero flags, kx, ky, fx, fy.
- S2 registers m, e, and the flags.
- S3 registers `q` and `dz`.
REQ-011 SHALL use a global advance enable en = !out_valid || out_ready, with in_ready = en.
REQ-012 SHALL advance all three stages together when en = 1, each stage loading its predecessor's payload and valid bit, with S1 valid loaded from `in_valid`.
REQ-013 SHALL hold all stage registers, including their valid bits, unchanged when en = 0. `q`, `dz` and `out_valid` SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-014 SHALL have a latency of exactly 3 clk edges from the input handshake to out_valid = 1 when out_ready is held high, with throughput of 1 result per cycle.
REQ-015 SHALL not collapse bubbles: an empty stage does not advance independently while en = 0.
REQ-016 SHALL increment `done_cnt` by 1 on each cycle with out_valid = 1 and out_ready = 1, wrapping from 16'hFFFF to 16'h0000.
REQ-017 SHALL ignore `x` and `y` when in_valid = 0. Stage payloads of invalid slots are don't-care, but `q` and `dz` SHALL retain their last values while out_valid = 0.

Reset
REQ-018 SHALL, on a rising clk edge with rst_n = 0, clear all stage valid bits and set out_valid = 0, q = 0, dz = 0, done_cnt = 0.
REQ-019 SHALL hold in_ready = 1 while out_valid = 0, including during reset.
REQ-020 SHALL drop every in-flight operand when reset is asserted mid-operation, so that no `out_valid` appears for operands accepted before reset.
REQ-021 SHALL treat reset as taking priority over any simultaneous handshake.

Verification
REQ-022 SHALL check x=15, y=5, out_ready=1 -> after 3 cycles out_valid=1, q=832 (3.25), dz=0.
REQ-023 SHALL check x=100, y=7 -> q=3712 (14.5); and x=-27, y=119 -> q=-58 (~-0.2266).
REQ-024 SHALL check the extremes:
- x=-256, y=1 -> q=-65536.
- x=1, y=-256 -> q=-1.
- x=0, y=18 -> q=0.
- x=5, y=0 -> q=131071, dz=1.
REQ-025 SHALL check back-to-back input on 4 consecutive cycles with out_ready=1 -> 4 consecutive results in order, and done_cnt advances 0 -> 4.
REQ-026 SHALL check out_ready=0 for 5 cycles while a result is valid -> `q` and `dz` are stable, in_ready=0, no result is lost, and the result order is preserved after release.
REQ-027 SHALL check rst_n=0 for 1 cycle with 2 operands in flight -> no out_valid follows, and done_cnt=0.
